mac_stream_unit: RTL

- Parametrised successor to the single-shot MAC.
- Accepts a stream of signed (a,b) operand pairs over a valid/ready handshake and accumulates their products across a vector terminated by in_last.
- Presents the dot-product result, beat count and overflow flag on an output valid/ready handshake.
- Has a two-stage pipeline (multiply, accumulate) and is the building block for the systolic array processing elements.

---
 rtl/mac_stream_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mac_stream_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mac_stream_unit
//
// Streaming multiply-accumulate. It accepts signed (a,b) operand pairs over a
// valid/ready handshake and accumulates their products until the pair flagged
// by in_last. The dot product, the number of pairs and a sticky overflow flag
// are then presented on an output valid/ready handshake. The pipeline has two
// stages: stage 1 registers the product and stage 2 accumulates it.
//
// Optional feature: define MAC_STREAM_SATURATE_EN to make the accumulator
// clamp on signed overflow. Without it the accumulator wraps. The overflow flag
// behaves the same way in both builds.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   in_valid   operand pair valid
//   in_ready   block can accept a pair this cycle
//   in_last    final pair of the current vector
//   a, b       signed operands, DATA_W bits
//   out_valid  result valid (held until out_ready)
//   out_ready  downstream accepts the result
//   y          signed accumulated result, ACC_W bits
//   count      pairs in the vector, saturating, CNT_W bits
//   overflow   sticky signed-overflow flag for the vector
// -----------------------------------------------------------------------------
module mac_stream_unit #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  y,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   localparam int PW = 2 * DATA_W;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    p_q, p_d;
   logic             p_valid_q, p_valid_d;
   logic             p_last_q, p_last_d;
   logic             p_first_q, p_first_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic [PW-1:0]    a_ext, b_ext, prod;
   logic [ACC_W-1:0] p_ext, acc_base, sum;
   logic             signed_ovf;

   // Both operands are sign-extended to the product width, so the low PW bits
   // of a plain multiply are the exact signed product.
   assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
   assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
   assign prod  = a_ext * b_ext;

   generate
      if (ACC_W > PW) begin : g_ext
         assign p_ext = {{(ACC_W-PW){p_q[PW-1]}}, p_q};
      end else begin : g_noext
         assign p_ext = p_q;
      end
   endgenerate

   // The first beat of a vector starts from zero so no earlier result carries over.
   assign acc_base   = p_first_q ? '0 : acc_q;
   assign sum        = acc_base + p_ext;
   assign signed_ovf = (acc_base[ACC_W-1] == p_ext[ACC_W-1]) &&
                       (sum[ACC_W-1] != acc_base[ACC_W-1]);

   assign in_ready  = !reset && ((state_q == IDLE) || (state_q == ACCUM));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == RESULT);
   assign y         = acc_q;
   assign count     = cnt_q;
   assign overflow  = ovf_q;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ACCUM: begin
            if (accept) state_d = in_last ? DRAIN : ACCUM;
         end
         DRAIN: begin
            // The last product commits to the accumulator on this edge.
            if (p_valid_q && p_last_q) state_d = RESULT;
         end
         RESULT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      p_valid_d = accept;
      p_d       = accept ? prod : p_q;
      p_last_d  = accept ? in_last : p_last_q;
      p_first_d = accept ? (state_q == IDLE) : p_first_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      if (p_valid_q) begin
`ifdef MAC_STREAM_SATURATE_EN
         if (signed_ovf)
            acc_d = acc_base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
         else
            acc_d = sum;
`else
         acc_d = sum;
`endif
         if (p_first_q)
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
         else if (cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
         ovf_d = (p_first_q ? 1'b0 : ovf_q) | signed_ovf;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         p_q       <= '0;
         p_valid_q <= 1'b0;
         p_last_q  <= 1'b0;
         p_first_q <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         p_q       <= p_d;
         p_valid_q <= p_valid_d;
         p_last_q  <= p_last_d;
         p_first_q <= p_first_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule
